// File: rtl/btn_defs.sv
// Shared definitions for the push-button front end.
// Contents:
//   BTN_*            channel index of each physical button on the btn_* buses
//   NBTN_DEF         number of button channels on the board
//   DEBOUNCE_DEFAULT default debounce interval in clk cycles (10 ms at 100 MHz)
//   SYNC_DEFAULT     default synchroniser depth
package btn_defs;

    localparam int BTN_RIGHT        = 0;
    localparam int BTN_LEFT         = 1;
    localparam int BTN_UP           = 2;
    localparam int BTN_DOWN         = 3;
    localparam int BTN_SHOOT        = 4;
    localparam int NBTN_DEF         = 5;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;
    localparam int SYNC_DEFAULT     = 2;

endpackage : btn_defs

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser chain, debounce counter, clean level
// and a registered one-cycle rising-edge pulse.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   raw_i    in  raw, unsynchronised button pin
//   level_o  out debounced level, 1 = pressed
//   rise_o   out one-cycle pulse in the first cycle level_o reads 1
module btn_debounce_ch
    import btn_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q,  rise_d;
    logic                   sync_s;

    // Shift the raw pin into the synchroniser; the last stage is the only safe sample.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
        sync_s = sync_q[SYNC_STAGES-1];
    end

    // Debounce: a differing input must persist DEBOUNCE_CYCLES cycles; any bounce
    // back to the accepted level restarts the count, so the counter cannot wrap.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_s;
            rise_d  = sync_s;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// Push-button front end: per-channel synchronise + debounce, plus a frame latch
// that captures every press between move ticks so short taps survive until the
// game logic samples them once per frame.
// Ports:
//   clk        in  100 MHz system clock
//   rst        in  asynchronous active-high reset
//   btn_raw    in  raw pins [0]=right [1]=left [2]=up [3]=down [4]=shoot
//   move       in  one-cycle frame tick (vblank start)
//   btn_level  out debounced levels, 1 = pressed
//   btn_rise   out one-cycle pulse when a level first reads 1
//   btn_frame  out presses latched for the current frame, updated only after move
module btn_conditioner
    import btn_defs::*;
#(
    parameter int NBTN            = NBTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            move,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_rise,
    output logic [NBTN-1:0] btn_frame
);

    logic [NBTN-1:0] pending_q, pending_d;
    logic [NBTN-1:0] frame_q,   frame_d;

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (btn_raw[i]),
            .level_o (btn_level[i]),
            .rise_o  (btn_rise[i])
        );
    end

    // Frame latch: a rise coincident with move goes straight into this frame
    // rather than into pending, so no press is ever deferred by a whole frame.
    always_comb begin
        pending_d = pending_q;
        frame_d   = frame_q;
        if (move) begin
            frame_d   = pending_q | btn_rise;
            pending_d = {NBTN{1'b0}};
        end else begin
            pending_d = pending_q | btn_rise;
        end
    end

    // Frame latch register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= {NBTN{1'b0}};
            frame_q   <= {NBTN{1'b0}};
        end else begin
            pending_q <= pending_d;
            frame_q   <= frame_d;
        end
    end

    assign btn_frame = frame_q;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
    import btn_defs::*;

    localparam int NB = 5;
    localparam int K_LEVEL = 0;
    localparam int K_RISE  = 1;
    localparam int K_FRAME = 2;
    localparam logic [NB-1:0] M_ALL = 5'b11111;

    typedef struct {
        int            cyc;
        int            kind;
        logic [NB-1:0] mask;
        logic [NB-1:0] val;
        logic [127:0]  name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = 5'b00000;
    logic          move = 1'b0;
    logic [NB-1:0] btn_level, btn_rise, btn_frame;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    btn_conditioner #(
        .NBTN            (NB),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .move      (move),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_frame (btn_frame)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NB-1:0] bit_of(int idx);
        logic [NB-1:0] one;
        one = 5'b00001;
        return one << idx;
    endfunction

    // Scoreboard insertion, kept ordered by expected cycle.
    function automatic void push_exp(int c, int kind, logic [NB-1:0] mask,
                                     logic [NB-1:0] val, logic [127:0] name);
        exp_t e;
        int   i;
        e.cyc = c; e.kind = kind; e.mask = mask; e.val = val; e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endfunction

    task automatic reset_dut();
        rst = 1'b1; btn_raw = 5'b00000; move = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; logic [NB-1:0] obs;
        for (int c = 1; c <= 3; c++) begin
            push_exp(c, K_LEVEL, M_ALL, 5'b00000, "rst_level");
            push_exp(c, K_RISE,  M_ALL, 5'b00000, "rst_rise");
            push_exp(c, K_FRAME, M_ALL, 5'b00000, "rst_frame");
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_press_latency();
        exp_t e; logic [NB-1:0] obs; int c0; logic [NB-1:0] m;
        reset_dut();
        m = bit_of(BTN_RIGHT);
        c0 = cyc;
        push_exp(c0 + 5, K_LEVEL, m, 5'b00000, "t1_level_early");
        push_exp(c0 + 5, K_RISE,  m, 5'b00000, "t1_rise_early");
        push_exp(c0 + 6, K_LEVEL, m, m,        "t1_level");
        push_exp(c0 + 6, K_RISE,  m, m,        "t1_rise");
        push_exp(c0 + 7, K_RISE,  m, 5'b00000, "t1_rise_off");
        push_exp(c0 + 7, K_LEVEL, m, m,        "t1_level_hold");
        for (int k = 0; k < 8; k++) begin
            if (k == 0) btn_raw[BTN_RIGHT] = 1'b1;
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e; logic [NB-1:0] obs; int c0; logic [NB-1:0] m;
        reset_dut();
        m = bit_of(BTN_UP);
        c0 = cyc;
        for (int c = 1; c <= 14; c++) begin
            push_exp(c0 + c, K_LEVEL, m, 5'b00000, "t2_level");
            push_exp(c0 + c, K_RISE,  m, 5'b00000, "t2_rise");
        end
        for (int k = 0; k < 14; k++) begin
            if (k == 0 || k == 4) btn_raw[BTN_UP] = 1'b1;
            if (k == 2 || k == 6) btn_raw[BTN_UP] = 1'b0;
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_shoot_tap();
        exp_t e; logic [NB-1:0] obs; int c0; logic [NB-1:0] m;
        reset_dut();
        m = bit_of(BTN_SHOOT);
        c0 = cyc;
        push_exp(c0 + 7,  K_LEVEL, m, m,        "t3_level_on");
        push_exp(c0 + 13, K_LEVEL, m, m,        "t3_level_held");
        push_exp(c0 + 14, K_LEVEL, m, 5'b00000, "t3_level_off");
        push_exp(c0 + 20, K_FRAME, m, 5'b00000, "t3_frame_pre");
        push_exp(c0 + 21, K_FRAME, m, m,        "t3_frame_set");
        push_exp(c0 + 30, K_FRAME, m, m,        "t3_frame_hold");
        push_exp(c0 + 31, K_FRAME, m, 5'b00000, "t3_frame_clr");
        for (int k = 0; k < 32; k++) begin
            move = (k == 0 || k == 20 || k == 30);
            if (k == 1) btn_raw[BTN_SHOOT] = 1'b1;
            if (k == 8) btn_raw[BTN_SHOOT] = 1'b0;
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
        move = 1'b0;
    endtask

    task automatic test_rise_on_move();
        exp_t e; logic [NB-1:0] obs; int c0; logic [NB-1:0] m;
        reset_dut();
        m = bit_of(BTN_SHOOT);
        c0 = cyc;
        push_exp(c0 + 6,  K_RISE,  m, m,        "t4_rise");
        push_exp(c0 + 6,  K_FRAME, m, 5'b00000, "t4_frame_pre");
        push_exp(c0 + 7,  K_FRAME, m, m,        "t4_frame_set");
        push_exp(c0 + 12, K_FRAME, m, m,        "t4_frame_hold");
        push_exp(c0 + 13, K_FRAME, m, 5'b00000, "t4_no_pending");
        for (int k = 0; k < 14; k++) begin
            move = (k == 6 || k == 12);
            if (k == 0) btn_raw[BTN_SHOOT] = 1'b1;
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
        move = 1'b0;
    endtask

    task automatic test_reset_midframe();
        exp_t e; logic [NB-1:0] obs; int c0; logic [NB-1:0] m;
        reset_dut();
        m = bit_of(BTN_LEFT);
        c0 = cyc;
        push_exp(c0 + 9, K_FRAME, m, m, "t5_frame_pre");
        for (int c = 13; c <= 15; c++) begin
            push_exp(c0 + c, K_LEVEL, M_ALL, 5'b00000, "t5_rst_level");
            push_exp(c0 + c, K_RISE,  M_ALL, 5'b00000, "t5_rst_rise");
            push_exp(c0 + c, K_FRAME, M_ALL, 5'b00000, "t5_rst_frame");
        end
        push_exp(c0 + 20, K_LEVEL, m, 5'b00000, "t5_level_early");
        push_exp(c0 + 21, K_LEVEL, m, m,        "t5_level_again");
        push_exp(c0 + 21, K_RISE,  m, m,        "t5_rise_again");
        push_exp(c0 + 21, K_FRAME, m, 5'b00000, "t5_frame_dropped");
        for (int k = 0; k < 22; k++) begin
            move = (k == 8);
            if (k == 0)  btn_raw[BTN_LEFT] = 1'b1;
            if (k == 12) rst = 1'b1;
            if (k == 15) rst = 1'b0;
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
        move = 1'b0;
    endtask

    task automatic test_all_buttons();
        exp_t e; logic [NB-1:0] obs; int c0;
        reset_dut();
        c0 = cyc;
        push_exp(c0 + 6,  K_RISE,  M_ALL, M_ALL,    "t6_rise_all");
        push_exp(c0 + 6,  K_LEVEL, M_ALL, M_ALL,    "t6_level_all");
        push_exp(c0 + 7,  K_RISE,  M_ALL, 5'b00000, "t6_rise_off");
        push_exp(c0 + 9,  K_FRAME, M_ALL, 5'b00000, "t6_frame_pre");
        push_exp(c0 + 10, K_FRAME, M_ALL, M_ALL,    "t6_frame_all");
        for (int k = 0; k < 11; k++) begin
            move = (k == 9);
            if (k == 0) btn_raw = M_ALL;
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                obs = (e.kind == K_LEVEL) ? btn_level : (e.kind == K_RISE) ? btn_rise : btn_frame;
                n_checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %0s cyc=%0d got=%b expected=%b", e.name, cyc, obs & e.mask, e.val & e.mask);
                end
            end
        end
        move = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d leftover expected=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_shoot_tap();
        test_rise_on_move();
        test_reset_midframe();
        test_all_buttons();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_btn_conditioner
